// File: rtl/gpu_pkg.sv
// Shared types for the line renderer GPU stage and its Bresenham stepper.
package gpu_pkg;

    localparam int H_RES_DEFAULT = 320;
    localparam int V_RES_DEFAULT = 240;

    typedef logic [9:0] coord_t;
    typedef logic [3:0] color_t;

    typedef struct packed {
        coord_t x0;
        coord_t y0;
        coord_t x1;
        coord_t y1;
        color_t color;
    } line_cmd_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_FETCH,
        ST_SETUP,
        ST_DRAW
    } render_state_t;

endpackage

// File: rtl/line_stepper.sv
// Bresenham core: load captures endpoints and error terms, advance walks one pixel.
module line_stepper
    import gpu_pkg::*;
(
    input  logic   clk,
    input  logic   load,
    input  coord_t x0,
    input  coord_t y0,
    input  coord_t x1,
    input  coord_t y1,
    input  logic   advance,
    output coord_t x,
    output coord_t y,
    output logic   last
);

    logic signed [11:0] ddx, ddy, adx, ady;
    logic signed [11:0] dx, dy, err;
    logic signed [12:0] e2, dx_w, dy_w;
    logic               sx_neg, sy_neg, step_x, step_y;
    coord_t             xe, ye;

    assign ddx = $signed({2'b00, x1}) - $signed({2'b00, x0});
    assign ddy = $signed({2'b00, y1}) - $signed({2'b00, y0});
    assign adx = ddx[11] ? -ddx : ddx;
    assign ady = ddy[11] ? -ddy : ddy;

    // e2 gets one extra bit so 2*err cannot wrap for full-width lines.
    assign e2     = {err, 1'b0};
    assign dx_w   = {dx[11], dx};
    assign dy_w   = {dy[11], dy};
    assign step_x = (e2 >= dy_w);
    assign step_y = (e2 <= dx_w);
    assign last   = (x == xe) && (y == ye);

    always_ff @(posedge clk) begin
        if (load) begin
            x      <= x0;
            y      <= y0;
            xe     <= x1;
            ye     <= y1;
            dx     <= adx;
            dy     <= -ady;
            sx_neg <= ddx[11];
            sy_neg <= ddy[11];
            err    <= adx - ady;
        end else if (advance) begin
            err <= err + (step_x ? dy : 12'sd0) + (step_y ? dx : 12'sd0);
            if (step_x) x <= sx_neg ? x - 10'd1 : x + 10'd1;
            if (step_y) y <= sy_neg ? y - 10'd1 : y + 10'd1;
        end
    end

endmodule

// File: rtl/line_renderer.sv
// Frame renderer: optional background clear, then Bresenham lines from a display list.
// Define LINE_RENDERER_CLEAR_EN to compile in the CLEAR pass.
module line_renderer
    import gpu_pkg::*;
#(
    parameter int H_RES      = H_RES_DEFAULT,
    parameter int V_RES      = V_RES_DEFAULT,
    parameter int LIST_DEPTH = 16
)(
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          gpu_start,
    input  logic                          list_we,
    input  logic [$clog2(LIST_DEPTH)-1:0] list_addr,
    input  coord_t                        list_x0,
    input  coord_t                        list_y0,
    input  coord_t                        list_x1,
    input  coord_t                        list_y1,
    input  color_t                        list_color,
    input  logic [$clog2(LIST_DEPTH):0]   list_len,
    input  color_t                        bg_color,
    output coord_t                        gpu_x,
    output coord_t                        gpu_y,
    output color_t                        gpu_data,
    output logic                          gpu_we,
    output logic                          gpu_done
);

    localparam int KW = $clog2(LIST_DEPTH);
    localparam int LW = KW + 1;
    localparam logic [LW-1:0] DEPTH_L = LW'(LIST_DEPTH);
    localparam coord_t H_LAST = coord_t'(H_RES - 1);
    localparam coord_t V_LAST = coord_t'(V_RES - 1);

    line_cmd_t     list_ram [LIST_DEPTH];
    line_cmd_t     cmd;
    render_state_t state, state_n;
    logic          sync1, sync2, sync3, start_pulse;
    logic [LW-1:0] len_q, len_n, len_clamped;
    logic [KW-1:0] k, k_n;
    color_t        color_q, color_n, data_n;
    coord_t        x_n, y_n, st_x, st_y;
    logic          we_n, done_n, last_q, last_n, st_last;
    logic          load, advance, emit;
`ifdef LINE_RENDERER_CLEAR_EN
    color_t        bg_q, bg_n;
    coord_t        cx, cy, cx_n, cy_n;
`else
    logic          unused_bg;
    assign unused_bg = ^bg_color;
`endif

    always_ff @(posedge clk) begin
        if (list_we) list_ram[list_addr] <= '{list_x0, list_y0, list_x1, list_y1, list_color};
    end

    assign cmd         = list_ram[k];
    assign start_pulse = sync2 & ~sync3;
    assign len_clamped = (list_len > DEPTH_L) ? DEPTH_L : list_len;

    line_stepper u_stepper (
        .clk     (clk),
        .load    (load),
        .x0      (cmd.x0),
        .y0      (cmd.y0),
        .x1      (cmd.x1),
        .y1      (cmd.y1),
        .advance (advance),
        .x       (st_x),
        .y       (st_y),
        .last    (st_last)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= ST_IDLE;
            sync1    <= 1'b0;
            sync2    <= 1'b0;
            sync3    <= 1'b0;
            len_q    <= '0;
            k        <= '0;
            color_q  <= '0;
            last_q   <= 1'b0;
            gpu_x    <= '0;
            gpu_y    <= '0;
            gpu_data <= '0;
            gpu_we   <= 1'b0;
            gpu_done <= 1'b1;
`ifdef LINE_RENDERER_CLEAR_EN
            bg_q     <= '0;
            cx       <= '0;
            cy       <= '0;
`endif
        end else begin
            state    <= state_n;
            sync1    <= gpu_start;
            sync2    <= sync1;
            sync3    <= sync2;
            len_q    <= len_n;
            k        <= k_n;
            color_q  <= color_n;
            last_q   <= last_n;
            gpu_x    <= x_n;
            gpu_y    <= y_n;
            gpu_data <= data_n;
            gpu_we   <= we_n;
            gpu_done <= done_n;
`ifdef LINE_RENDERER_CLEAR_EN
            bg_q     <= bg_n;
            cx       <= cx_n;
            cy       <= cy_n;
`endif
        end
    end

    // Outputs are computed one cycle ahead and registered with the state.
    always_comb begin
        state_n = state;
        len_n   = len_q;
        k_n     = k;
        color_n = color_q;
        last_n  = last_q;
        x_n     = gpu_x;
        y_n     = gpu_y;
        data_n  = gpu_data;
        we_n    = 1'b0;
        done_n  = 1'b0;
        load    = 1'b0;
        advance = 1'b0;
        emit    = 1'b0;
`ifdef LINE_RENDERER_CLEAR_EN
        bg_n    = bg_q;
        cx_n    = cx;
        cy_n    = cy;
`endif
        case (state)
            ST_IDLE: begin
                done_n = 1'b1;
                if (start_pulse) begin
                    len_n = len_clamped;
                    k_n   = '0;
`ifdef LINE_RENDERER_CLEAR_EN
                    bg_n    = bg_color;
                    state_n = ST_CLEAR;
                    done_n  = 1'b0;
                    we_n    = 1'b1;
                    x_n     = '0;
                    y_n     = '0;
                    data_n  = bg_color;
                    cx_n    = '0;
                    cy_n    = '0;
`else
                    if (len_clamped != '0) begin
                        state_n = ST_FETCH;
                        done_n  = 1'b0;
                    end
`endif
                end
            end
`ifdef LINE_RENDERER_CLEAR_EN
            ST_CLEAR: begin
                if (cx == H_LAST && cy == V_LAST) begin
                    if (len_q == '0) begin
                        state_n = ST_IDLE;
                        done_n  = 1'b1;
                    end else begin
                        state_n = ST_FETCH;
                    end
                end else begin
                    if (cx == H_LAST) begin
                        cx_n = '0;
                        cy_n = cy + 10'd1;
                    end else begin
                        cx_n = cx + 10'd1;
                    end
                    we_n   = 1'b1;
                    x_n    = cx_n;
                    y_n    = cy_n;
                    data_n = bg_q;
                end
            end
`endif
            ST_FETCH: begin
                load    = 1'b1;
                color_n = cmd.color;
                state_n = ST_SETUP;
            end
            ST_SETUP: begin
                emit    = 1'b1;
                state_n = ST_DRAW;
            end
            ST_DRAW: begin
                if (last_q) begin
                    if (({1'b0, k} + LW'(1)) < len_q) begin
                        k_n     = k + KW'(1);
                        state_n = ST_FETCH;
                    end else begin
                        state_n = ST_IDLE;
                        done_n  = 1'b1;
                    end
                end else begin
                    emit = 1'b1;
                end
            end
            default: state_n = ST_IDLE;
        endcase

        // Off-screen pixels still consume their cycle but are not written.
        if (emit) begin
            x_n     = st_x;
            y_n     = st_y;
            data_n  = color_q;
            we_n    = (st_x <= H_LAST) && (st_y <= V_LAST);
            last_n  = st_last;
            advance = !st_last;
        end
    end

endmodule

// File: tb/tb_line_renderer.sv
// Scoreboard bench for line_renderer; expectations follow LINE_RENDERER_CLEAR_EN when defined.
`timescale 1ns/1ps
module tb_line_renderer;

    localparam int H = 320;
`ifdef LINE_RENDERER_CLEAR_EN
    localparam int V   = 16;
    localparam int CLR = H * V;
`else
    localparam int V   = 240;
    localparam int CLR = 0;
`endif
    localparam int DEPTH = 16;

    logic       clk = 1'b0;
    logic       reset, gpu_start, list_we;
    logic [3:0] list_addr;
    logic [9:0] list_x0, list_y0, list_x1, list_y1;
    logic [3:0] list_color, bg_color;
    logic [4:0] list_len;
    logic [9:0] gpu_x, gpu_y;
    logic [3:0] gpu_data;
    logic       gpu_we, gpu_done;

    logic [23:0] exp_q[$];
    logic [23:0] mon_want;
    bit          mon_have;
    int          n_vec = 0;
    int          n_err = 0;
    int          low_cnt = 0;

    always #5 clk = ~clk;

    line_renderer #(.H_RES(H), .V_RES(V), .LIST_DEPTH(DEPTH)) dut (
        .clk        (clk),
        .reset      (reset),
        .gpu_start  (gpu_start),
        .list_we    (list_we),
        .list_addr  (list_addr),
        .list_x0    (list_x0),
        .list_y0    (list_y0),
        .list_x1    (list_x1),
        .list_y1    (list_y1),
        .list_color (list_color),
        .list_len   (list_len),
        .bg_color   (bg_color),
        .gpu_x      (gpu_x),
        .gpu_y      (gpu_y),
        .gpu_data   (gpu_data),
        .gpu_we     (gpu_we),
        .gpu_done   (gpu_done)
    );

    task automatic check(input string tag, input int obs, input int want);
        n_vec++;
        assert (obs === want) else begin
            n_err++;
            $error("FAIL %s: got %0d, want %0d", tag, obs, want);
        end
    endtask

    task automatic push_px(input int x, input int y, input int c);
        exp_q.push_back({10'(x), 10'(y), 4'(c)});
    endtask

    task automatic expect_clear();
`ifdef LINE_RENDERER_CLEAR_EN
        for (int yy = 0; yy < V; yy++)
            for (int xx = 0; xx < H; xx++)
                push_px(xx, yy, int'(bg_color));
`endif
    endtask

    task automatic write_entry(input int a, input int x0, input int y0,
                               input int x1, input int y1, input int c);
        @(negedge clk);
        list_we    = 1'b1;
        list_addr  = 4'(a);
        list_x0    = 10'(x0);
        list_y0    = 10'(y0);
        list_x1    = 10'(x1);
        list_y1    = 10'(y1);
        list_color = 4'(c);
        @(negedge clk);
        list_we = 1'b0;
    endtask

    task automatic run_frame(input string tag, input int exp_len, input int repulse);
        int lat;
        int t;
        @(negedge clk);
        gpu_start = 1'b1;
        low_cnt   = 0;
        lat       = 0;
        do begin
            @(negedge clk);
            gpu_start = 1'b0;
            lat++;
        end while (gpu_done && lat < 20);
        check({tag, "_latency"}, lat, 3);
        t = 0;
        while (!gpu_done && t < exp_len + 50) begin
            @(negedge clk);
            t++;
            gpu_start = (repulse != 0) && (t == repulse);
        end
        gpu_start = 1'b0;
        check({tag, "_frame_len"}, low_cnt, exp_len);
        check({tag, "_drained"}, exp_q.size(), 0);
        repeat (4) @(negedge clk);
        check({tag, "_done_hold"}, int'(gpu_done), 1);
    endtask

    initial begin
        int t;
        reset      = 1'b1;
        gpu_start  = 1'b0;
        list_we    = 1'b0;
        list_addr  = '0;
        list_x0    = '0;
        list_y0    = '0;
        list_x1    = '0;
        list_y1    = '0;
        list_color = '0;
        list_len   = '0;
        bg_color   = 4'd5;

        fork
            forever begin
                @(negedge clk);
                if (!gpu_done) low_cnt++;
                if (gpu_we) begin
                    n_vec++;
                    mon_have = (exp_q.size() != 0);
                    assert (mon_have) else begin
                        n_err++;
                        $error("FAIL write_unexpected: got (%0d,%0d)=%0d, want no write",
                               gpu_x, gpu_y, gpu_data);
                    end
                    if (mon_have) begin
                        mon_want = exp_q.pop_front();
                        assert ({gpu_x, gpu_y, gpu_data} === mon_want) else begin
                            n_err++;
                            $error("FAIL pixel: got (%0d,%0d)=%0d, want (%0d,%0d)=%0d",
                                   gpu_x, gpu_y, gpu_data,
                                   mon_want[23:14], mon_want[13:4], mon_want[3:0]);
                        end
                    end
                end
            end
        join_none

        repeat (3) @(negedge clk);
        check("rst_done", int'(gpu_done), 1);
        check("rst_we", int'(gpu_we), 0);
        check("rst_x", int'(gpu_x), 0);
        check("rst_y", int'(gpu_y), 0);
        check("rst_data", int'(gpu_data), 0);
        reset = 1'b0;
        @(negedge clk);
        check("idle_done", int'(gpu_done), 1);

`ifdef LINE_RENDERER_CLEAR_EN
        list_len = 5'd0;
        expect_clear();
        run_frame("clear_only", CLR, 0);
`endif
        bg_color = 4'd2;

        write_entry(0, 0, 0, 3, 0, 9);
        list_len = 5'd1;
        expect_clear();
        for (int i = 0; i < 4; i++) push_px(i, 0, 9);
        run_frame("hline", CLR + 6, 0);

        write_entry(0, 10, 10, 13, 12, 15);
        expect_clear();
        push_px(10, 10, 15); push_px(11, 11, 15); push_px(12, 11, 15); push_px(13, 12, 15);
        run_frame("diag", CLR + 6, 0);

        write_entry(0, 13, 12, 10, 10, 15);
        expect_clear();
        push_px(13, 12, 15); push_px(12, 11, 15); push_px(11, 11, 15); push_px(10, 10, 15);
        run_frame("diag_rev", CLR + 6, 0);

        write_entry(0, 2, 0, 3, 3, 6);
        expect_clear();
        push_px(2, 0, 6); push_px(2, 1, 6); push_px(3, 2, 6); push_px(3, 3, 6);
        run_frame("steep", CLR + 6, 0);

        write_entry(0, 318, 0, 321, 0, 4);
        write_entry(1, 0, V - 2, 0, V + 1, 8);
        list_len = 5'd2;
        expect_clear();
        push_px(318, 0, 4); push_px(319, 0, 4); push_px(0, V - 2, 8); push_px(0, V - 1, 8);
        run_frame("clip", CLR + 12, 0);

        write_entry(0, 5, 5, 5, 5, 1);
        list_len = 5'd1;
        expect_clear();
        push_px(5, 5, 1);
        run_frame("degenerate", CLR + 3, 0);

        for (int i = 0; i < DEPTH; i++) write_entry(i, i, 20, i, 20, i);
        list_len = 5'd31;
        expect_clear();
        for (int i = 0; i < DEPTH; i++) push_px(i, 20, i);
        run_frame("len_clamp", CLR + 3 * DEPTH, 0);

        write_entry(0, 0, 5, 40, 5, 7);
        list_len = 5'd1;
        expect_clear();
        for (int i = 0; i <= 40; i++) push_px(i, 5, 7);
        run_frame("repulse", CLR + 43, 20);

        write_entry(0, 0, 50, 99, 50, 3);
        expect_clear();
        for (int i = 0; i < 100; i++) push_px(i, 50, 3);
        @(negedge clk);
        gpu_start = 1'b1;
        @(negedge clk);
        gpu_start = 1'b0;
        t = 0;
        while (exp_q.size() > 90 && t < CLR + 500) begin
            @(negedge clk);
            t++;
        end
        check("abort_in_draw", int'(exp_q.size() <= 90), 1);
        reset = 1'b1;
        #1;
        check("abort_done", int'(gpu_done), 1);
        check("abort_we", int'(gpu_we), 0);
        @(negedge clk);
        reset = 1'b0;
        exp_q.delete();
        @(negedge clk);
        check("abort_idle", int'(gpu_done), 1);

        expect_clear();
        for (int i = 0; i < 100; i++) push_px(i, 50, 3);
        run_frame("after_abort", CLR + 102, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/line_renderer.md
# line_renderer

Upstream GPU stage that feeds the double-buffered frame director. On each `gpu_start` request it optionally clears the back buffer to a background colour, then rasterises a small display list of straight lines with Bresenham's algorithm. It emits one pixel write per cycle on the director's `gpu_x`/`gpu_y`/`gpu_data`/`gpu_we` bus and holds `gpu_done` high when the frame is complete. Runs entirely in the 150 MHz GPU clock domain.

## Interface
Parameters:
- `H_RES`, 320: visible width in pixels.
- `V_RES`, 240: visible height in pixels.
- `LIST_DEPTH`, 16: number of display-list entries.

Ports (one clock; reset is asynchronous and active-high):
- `clk`  in  1  GPU clock (150 MHz).
- `reset`  in  1  asynchronous, active-high.
- `gpu_start`  in  1  frame request from the frame director; generated in another domain.
- `list_we`  in  1  display-list entry write strobe.
- `list_addr`  in  $clog2(LIST_DEPTH)  entry index.
- `list_x0`, `list_y0`, `list_x1`, `list_y1`  in  10 each  line endpoints.
- `list_color`  in  4  line intensity.
- `list_len`  in  $clog2(LIST_DEPTH)+1  number of entries to draw; sampled at frame start.
- `bg_color`  in  4  clear colour; sampled at frame start.
- `gpu_x`, `gpu_y`  out  10 each  pixel coordinate.
- `gpu_data`  out  4  pixel value.
- `gpu_we`  out  1  pixel write strobe.
- `gpu_done`  out  1  frame complete / idle.

## Operation
- `gpu_start` passes through a 2-flop synchroniser. A frame begins on a rising edge of the synchronised signal, but only in IDLE; rising edges seen in any other state are ignored.
- States:
  - IDLE: `gpu_done`=1.
  - CLEAR: sweep in raster order from (0,0) to (H_RES-1,V_RES-1), writing `bg_color`.
  - FETCH: read entry k.
  - SETUP: compute the Bresenham terms.
  - DRAW: emit pixels.
  - Then the next entry, or back to IDLE.
- Transitions:
  - IDLE→CLEAR on start.
  - CLEAR→FETCH after the last pixel, or CLEAR→IDLE when the latched length is 0.
  - DRAW→FETCH when the endpoint has been emitted and k+1 < length; otherwise DRAW→IDLE.
- At frame start: `list_len` is latched and clamped to LIST_DEPTH, and `bg_color` is latched.
- Bresenham setup (signed 12-bit arithmetic):
  - dx=|x1-x0|, dy=-|y1-y0|, sx/sy=±1, err=dx+dy.
  - Each DRAW cycle emits (x,y), then computes e2=2·err.
  - If e2≥dy: err+=dy, x+=sx. If e2≤dx: err+=dx, y+=sy.
  - Endpoints are inclusive; a line emits max(dx,|dy|)+1 pixels.
  - A degenerate line (x0=x1, y0=y1) emits exactly 1 pixel.
- Clipping: a pixel with x≥H_RES or y≥V_RES still takes its cycle, with `gpu_we`=0.
- Display-list writes are accepted in every state. An entry is copied into working registers at FETCH, so a write lands in the current frame only if that entry has not yet been fetched.
- Reset:
  - Outputs return to IDLE values immediately: `gpu_done`=1, `gpu_we`=0, `gpu_x`=`gpu_y`=0, `gpu_data`=0.
  - Synchroniser cleared; latched length set to 0.
  - List RAM contents are not reset.
  - Reset asserted mid-frame abandons the frame.

## Timing
- Start latency: a rising edge on `gpu_start` causes `gpu_done` to fall 3 cycles later (2 synchroniser cycles + 1 registered state update). The first CLEAR write appears in that same cycle.
- All outputs are registered. `gpu_x`/`gpu_y`/`gpu_data` are only meaningful while `gpu_we`=1.
- Frame length (cycles from `gpu_done` falling to rising) = H_RES·V_RES + Σ(2 + pixels_k), where the 2 covers FETCH and SETUP.
- `gpu_done` rises in the cycle after the last write; `gpu_we`=0 in that cycle.
- `gpu_done` stays high until the next accepted start.

## Configuration
- `LINE_RENDERER_CLEAR_EN` defined: the CLEAR pass runs as described.
- Undefined: the CLEAR state is not compiled; IDLE goes directly to FETCH, and `bg_color` is unused. The previous buffer contents persist under the new lines, and frame length drops by H_RES·V_RES.

## Structure
- Package `gpu_pkg`:
  - `H_RES_DEFAULT`, `V_RES_DEFAULT`
  - `coord_t` (logic [9:0]), `color_t` (logic [3:0])
  - packed struct `line_cmd_t` {x0,y0,x1,y1,color}
  - state enum `render_state_t`
- Sub-module `line_stepper`: Bresenham core.
  - Inputs: load, endpoints, advance.
  - Outputs: current x/y, last-pixel flag.
- Top level: synchroniser, FSM, clear counters, list RAM (LIST_DEPTH × `line_cmd_t`).

## Test plan
- Reset, then a `gpu_start` pulse with `list_len`=0, `bg_color`=5 → exactly 76800 writes of 5, in raster order; `gpu_done` low for exactly 76800 cycles.
- Entry 0 = (0,0)→(3,0), colour 9, `list_len`=1 → after the clear, writes (0,0),(1,0),(2,0),(3,0); frame length 76806.
- Entry (10,10)→(13,12), colour 15 → pixels (10,10),(11,11),(12,11),(13,12); also the reversed line (13,12)→(10,10) emits 4 pixels ending at (10,10).
- Entry (318,0)→(321,0) → `gpu_we` high for x=318,319 and low for x=320,321; 4 cycles consumed.
- `gpu_start` re-pulsed mid-CLEAR → ignored, frame completes normally. Reset asserted mid-DRAW → `gpu_done`=1 and `gpu_we`=0 immediately; the next start renders a full frame.
- With `LINE_RENDERER_CLEAR_EN` undefined: one degenerate entry (5,5)→(5,5) → a single write at (5,5); `gpu_done` low for 3 cycles.
